// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the wide add/subtract controller and its 16-bit slice adder.
package adder_ctrl_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/ripple_adder.sv
// 16-bit ripple-carry adder; the one slice adder shared by wide_add_ctrl.
module ripple_adder
  import adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               cin,
  output logic [SLICE_W-1:0] S,
  output logic               cout
);

  logic carry;

  always_comb begin
    S     = '0;
    carry = cin;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/wide_add_ctrl.sv
// Multi-cycle SLICES x 16-bit add/subtract that walks one shared 16-bit adder
// across the operands, LSB slice first, chaining the carry between slices.
module wide_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned SLICES = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [SLICE_W*SLICES-1:0] A,
  input  logic [SLICE_W*SLICES-1:0] B,
  input  logic                      cin,
  output logic [SLICE_W*SLICES-1:0] S,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned W     = SLICE_W * SLICES;
  localparam int unsigned IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       op_a, op_b;
  logic               carry;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;
  logic               last_slice;

  assign slice_a    = op_a[SLICE_W*idx +: SLICE_W];
  assign slice_b    = op_b[SLICE_W*idx +: SLICE_W];
  assign last_slice = (idx == IDX_W'(SLICES - 1));

  ripple_adder u_adder (
    .A    (slice_a),
    .B    (slice_b),
    .cin  (carry),
    .S    (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_slice) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Subtract is A + ~B + 1: invert B at acceptance and force the initial carry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= A;
            op_b  <= op_sub ? ~B : B;
            carry <= op_sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          S[SLICE_W*idx +: SLICE_W] <= slice_sum;
          carry                     <= slice_cout;
          if (last_slice) begin
            cout <= slice_cout;
            ovf  <= (op_a[W-1] == op_b[W-1]) && (slice_sum[SLICE_W-1] != op_a[W-1]);
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_ctrl.sv
// Self-checking bench for wide_add_ctrl: directed corner cases plus random
// add/subtract traffic against an exact-integer reference model.
module tb_wide_add_ctrl;

  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = 16 * SLICES;
  localparam int          LAT    = SLICES;

  logic         Clk, Reset, start, op_sub, cin;
  logic [W-1:0] A, B, S;
  logic         cout, ovf, busy, done;

  int total = 0;
  int bad   = 0;

  wide_add_ctrl #(.SLICES(SLICES)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (start),
    .op_sub (op_sub),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .S      (S),
    .cout   (cout),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, result taken modulo 2^W,
  // overflow = exact signed result outside the W-bit signed range.
  task automatic model(input logic [W-1:0] a, b, input logic c, sub,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0]           u;
    logic signed [W+1:0]  sx, lo, hi;
    if (sub) begin
      u  = {1'b0, a} + {1'b0, ~b} + 1'b1;
      sx = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      sx = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
    end
    lo = -($signed({2'b00, {W{1'b0}}} | ({{(W+1){1'b0}}, 1'b1} << (W-1))));
    hi = $signed(({{(W+1){1'b0}}, 1'b1} << (W-1))) - 1;
    s  = u[W-1:0];
    co = u[W];
    ov = (sx < lo) || (sx > hi);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, b, input logic c, sub);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    model(a, b, c, sub, es, ec, eo);
    @(negedge Clk);
    A = a; B = b; cin = c; op_sub = sub; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    A = $urandom(); B = $urandom();
    check_val({tag, ".busy"}, busy, 1);
    wait_done(lat);
    check_val({tag, ".lat"}, lat, LAT);
    check_val({tag, ".S"}, S, es);
    check_val({tag, ".cout"}, cout, ec);
    check_val({tag, ".ovf"}, ovf, eo);
    @(posedge Clk); #1;
    check_val({tag, ".done1cyc"}, done, 0);
    check_val({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] a0, b0, a1, b1, es, r1, r2;
    logic         ec, eo;
    int           lat;

    Reset = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;

    do_op("add_carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);

    // Asynchronous reset between edges
    @(negedge Clk); #2;
    Reset = 1'b1; #1;
    check_val("rst.S", S, 0);
    check_val("rst.cout", cout, 0);
    check_val("rst.ovf", ovf, 0);
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    @(negedge Clk); Reset = 1'b0;

    do_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    do_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    do_op("sub_neg", 64'h5, 64'h7, 1'b1, 1'b1);
    do_op("sub_pos", 64'h7, 64'h5, 1'b1, 1'b1);
    do_op("add_cin", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    do_op("sub_min", 64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // start held high with operands changing every cycle
    a0 = {$urandom(), $urandom()}; b0 = {$urandom(), $urandom()};
    model(a0, b0, 1'b0, 1'b0, es, ec, eo);
    @(negedge Clk);
    A = a0; B = b0; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(posedge Clk); #1;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge Clk);
      A = {$urandom(), $urandom()}; B = {$urandom(), $urandom()};
      @(posedge Clk); #1;
      check_val($sformatf("hold.done%0d", i), done, (i == LAT));
    end
    check_val("hold.S", S, es);
    check_val("hold.cout", cout, ec);
    @(negedge Clk);
    a1 = {$urandom(), $urandom()}; b1 = {$urandom(), $urandom()};
    A = a1; B = b1;
    @(posedge Clk); #1;
    check_val("hold.idle", busy, 0);
    @(negedge Clk);
    model(A, B, 1'b0, 1'b0, es, ec, eo);
    @(posedge Clk); #1;
    check_val("hold.reaccept", busy, 1);
    start = 1'b0;
    A = '0; B = '0;
    wait_done(lat);
    check_val("hold2.lat", lat, LAT);
    check_val("hold2.S", S, es);
    @(posedge Clk); #1;

    // Reset during RUN at idx=2
    @(negedge Clk);
    A = 64'hAAAA_BBBB_CCCC_DDDD; B = 64'h1111_2222_3333_4444; op_sub = 1'b0; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1; #1;
    check_val("midrst.S", S, 0);
    check_val("midrst.busy", busy, 0);
    check_val("midrst.done", done, 0);
    @(posedge Clk); #1;
    @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge Clk); #1;
      check_val("midrst.nodone", done, 0);
    end
    do_op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      if (n % 4 == 0) r2 = ~r1;
      do_op($sformatf("rnd%0d", n), r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
